// File: rtl/div_pkg.sv
// Shared widths and FSM state encoding for the sequential 32/16 divider.
// Latency: none (declarations only).
// Backpressure: not applicable.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 32;
    localparam int unsigned DIVISOR_W  = 16;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DZERO = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare, subtract, emit quotient bit.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle the parent chooses to use it.
module div_step
    import div_pkg::*;
(
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] rem_shift;
    logic [DIVISOR_W+1:0] diff;

    // Top bit of diff is the borrow whenever rem_shift fits below 2^17; a set
    // top bit of rem_shift always exceeds any 16-bit divisor.
    always_comb begin
        rem_shift = {rem_in, bit_in};
        diff      = rem_shift - {2'b00, divisor};
        q_bit     = rem_shift[DIVISOR_W+1] | ~diff[DIVISOR_W+1];
        rem_out   = q_bit ? diff[DIVISOR_W:0] : rem_shift[DIVISOR_W:0];
    end

endmodule

// File: rtl/div32x16_seq.sv
// Sequential unsigned 32/16 restoring divider with zero-divisor handling.
// Latency: 16 cycles busy (a < 2^16), 32 cycles otherwise, 1 cycle for b==0; done pulses one cycle after.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
module div32x16_seq
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] a,
    input  logic [DIVISOR_W-1:0]  b,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    state_t                state;
    logic [DIVIDEND_W-1:0] a_reg;
    logic [DIVISOR_W-1:0]  b_reg;
    logic [DIVISOR_W:0]    rem_reg;
    logic [CNT_W-1:0]      cnt;

    logic [DIVISOR_W:0]    rem_next;
    logic                  q_bit;

    div_step u_step (
        .rem_in  (rem_reg),
        .bit_in  (a_reg[cnt]),
        .divisor (b_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // Control FSM plus datapath registers; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            rem_reg     <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        busy  <= 1'b1;
                        if (b != '0) begin
                            b_reg       <= b;
                            rem_reg     <= '0;
                            quotient    <= '0;
                            div_by_zero <= 1'b0;
                            // Small dividends skip the all-zero upper half.
                            cnt         <= (a[DIVIDEND_W-1:DIVISOR_W] == '0) ? CNT_W'(15) : CNT_W'(31);
                            state       <= CALC;
                        end else begin
                            state <= DZERO;
                        end
                    end
                end
                CALC: begin
                    rem_reg        <= rem_next;
                    remainder      <= rem_next[DIVISOR_W-1:0];
                    quotient[cnt]  <= q_bit;
                    cnt            <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DZERO: begin
                    quotient    <= '1;
                    remainder   <= a_reg[DIVISOR_W-1:0];
                    div_by_zero <= 1'b1;
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32x16_seq.sv
// Self-checking bench for div32x16_seq: directed cases plus randomized divisions
// compared against plain integer arithmetic.
module tb_div32x16_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_tests;
    int n_fail;

    div32x16_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " busy"}, {63'd0, busy}, 64'd0);
        check({tag, " done"}, {63'd0, done}, 64'd0);
        check({tag, " quotient"}, {32'd0, quotient}, 64'd0);
        check({tag, " remainder"}, {48'd0, remainder}, 64'd0);
        check({tag, " div_by_zero"}, {63'd0, div_by_zero}, 64'd0);
    endtask

    // Called at a negedge while the DUT is idle; returns at the first busy negedge.
    task automatic launch(input logic [31:0] av, input logic [15:0] bv, input string tag);
        start = 1'b1;
        a     = av;
        b     = bv;
        check({tag, " busy low at accept"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = 16'($urandom);
    endtask

    // Counts busy cycles, optionally re-pulses start mid-operation, then checks
    // results at the done negedge against the arithmetic model. Returns in the done cycle.
    task automatic finish(input logic [31:0] av, input logic [15:0] bv, input int pulse_at,
                          input string tag);
        logic [31:0] exp_q;
        logic [15:0] exp_r;
        logic        exp_dz;
        int          exp_cycles;
        int          cycles;
        int          done_early;
        if (bv == 16'd0) begin
            exp_q      = 32'hFFFF_FFFF;
            exp_r      = av[15:0];
            exp_dz     = 1'b1;
            exp_cycles = 1;
        end else begin
            exp_q      = av / {16'd0, bv};
            exp_r      = 16'(av % {16'd0, bv});
            exp_dz     = 1'b0;
            exp_cycles = (av < 32'h0001_0000) ? 16 : 32;
        end
        cycles     = 0;
        done_early = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (done === 1'b1) done_early++;
            if (pulse_at != 0 && cycles == pulse_at) begin
                start = 1'b1;
                a     = 32'd5;
                b     = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy cycles"}, 64'(cycles), 64'(exp_cycles));
        check({tag, " done low while busy"}, 64'(done_early), 64'd0);
        check({tag, " done pulse"}, {63'd0, done}, 64'd1);
        check({tag, " quotient"}, {32'd0, quotient}, {32'd0, exp_q});
        check({tag, " remainder"}, {48'd0, remainder}, {48'd0, exp_r});
        check({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
    endtask

    // Cycle after done: pulse must have dropped and results must hold.
    task automatic check_hold(input logic [31:0] eq, input logic [15:0] er, input string tag);
        @(negedge clk);
        check({tag, " done dropped"}, {63'd0, done}, 64'd0);
        check({tag, " quotient held"}, {32'd0, quotient}, {32'd0, eq});
        check({tag, " remainder held"}, {48'd0, remainder}, {48'd0, er});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        #2;
        check_cleared("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_cleared("post-reset idle");

        // Fast path.
        launch(32'd100, 16'd7, "fast");
        finish(32'd100, 16'd7, 0, "fast");
        check({"fast quotient literal"}, {32'd0, quotient}, 64'd14);
        check({"fast remainder literal"}, {48'd0, remainder}, 64'd2);
        check_hold(32'd14, 16'd2, "fast");

        // Full 32-iteration path.
        launch(32'h1234_5678, 16'h1234, "full");
        finish(32'h1234_5678, 16'h1234, 0, "full");
        check("full quotient literal", {32'd0, quotient}, 64'h0001_0004);
        check("full remainder literal", {48'd0, remainder}, 64'h0DA8);
        check_hold(32'h0001_0004, 16'h0DA8, "full");

        // Divide by zero.
        launch(32'hDEAD_BEEF, 16'd0, "dzero");
        finish(32'hDEAD_BEEF, 16'd0, 0, "dzero");
        check_hold(32'hFFFF_FFFF, 16'hBEEF, "dzero");

        // Start re-pulsed with new operands mid-operation must be ignored.
        launch(32'hFFFF_FFFF, 16'd1, "ignore start");
        finish(32'hFFFF_FFFF, 16'd1, 5, "ignore start");
        check_hold(32'hFFFF_FFFF, 16'd0, "ignore start");

        // Back-to-back: second start issued in the done cycle.
        launch(32'h0008_0000, 16'd3, "b2b first");
        finish(32'h0008_0000, 16'd3, 0, "b2b first");
        launch(32'd9, 16'd3, "b2b second");
        finish(32'd9, 16'd3, 0, "b2b second");
        check_hold(32'd3, 16'd0, "b2b second");

        // Asynchronous reset in the middle of a 32-cycle divide.
        launch(32'h1234_5678, 16'h1234, "abort");
        repeat (9) @(negedge clk);
        check("abort still busy", {63'd0, busy}, 64'd1);
        #1 reset = 1'b1;
        #1;
        check_cleared("async reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_cleared("after abort idle");
        launch(32'd100, 16'd7, "after abort");
        finish(32'd100, 16'd7, 0, "after abort");

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra;
            logic [15:0] rb;
            int          mode;
            mode = int'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = 16'($urandom);
            if (mode == 0) ra = {16'd0, ra[15:0]};
            if (mode == 1) rb = 16'd0;
            if (mode == 2) rb = {8'd0, rb[7:0]};
            launch(ra, rb, "random");
            finish(ra, rb, 0, "random");
            if (rb != 16'd0)
                check("random identity", 64'(quotient) * 64'(rb) + 64'(remainder), 64'(ra));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
